pw_conv_pre_process: RTL and testbench
======================================

// Module: pw_conv_pre_process
// PURPOSE
//  Pre-processing stage in front of the pointwise (1x1) convolution array.
//  - Accepts two adjacent pixels per cycle. Each pixel carries 9 channels of signed INT8 data.
//  - Combines the two pixels channel-by-channel into one 9-channel INT8 pixel (2:1 spatial reduction).
//  - Free-running, fully pipelined stream: no handshake, one result per clock.
// PARAMETERS
//  MODE  0  combine op: 0 = signed max, 1 = rounded signed average, 2 = saturating signed sum
//  CH    9  channels per pixel (fixed at 9 for the 144/72-bit ports; do not override)
//  DW    8  bits per channel (fixed at 8; do not override)
// PORTS
//  clk       input   1    system clock, all logic on rising edge
//  rstn      input   1    reset, synchronous, active-low
//  data_in   input   144  pixel A = [71:0], pixel B = [143:72]; channel c of each pixel at [8c+7:8c] of that half
//  data_out  output  72   combined pixel; channel c at [8c+7:8c], signed INT8
// BEHAVIOUR
//  - Single clock domain. Reset is synchronous and active-low: sampled only on the rising edge of clk.
//    - Block is reset solely by rstn; no dependency on any vendor global-reset primitive.
//  - Pipeline, 2 register stages:
//    - S1: data_in registered unconditionally.
//    - S2: per-channel combine of the S1 register, registered to data_out.
//  - Latency: the value on data_in at edge k appears on data_out after edge k+2.
//    - Throughput is 1 pixel pair per clock.
//  - Reset: while rstn=0 at a rising edge, the S1 register and data_out are cleared to 0.
//    - Reset applied mid-stream flushes the pipeline; no partial results survive.
//    - First non-reset data_out appears 2 edges after the first edge sampled with rstn=1.
//      The edge in between still shows 0.
//  - Per channel c, with a = A[c] and b = B[c] as signed 8-bit:
//    - MODE 0: out = (a > b) ? a : b, signed compare.
//    - MODE 1: out = (a + b + 1) >>> 1.
//      - 9-bit signed intermediate, arithmetic shift, round half up.
//      - Result always fits in 8 bits.
//    - MODE 2: s = a + b in 9 bits, then clamp.
//      - s > 127 -> 0x7F; s < -128 -> 0x80; otherwise s[7:0].
//  - Channels are fully independent: no carry or borrow crosses channel boundaries.
//  - Illegal MODE values (3+): behave as MODE 0.
//  - No X propagation: all registers have defined reset values.
// TESTING
//  1) Reset:
//     - rstn=0 for 10 clocks with data_in=144'h1 -> data_out=0 every cycle.
//     - Release -> data_out still 0 at the 1st edge, 72'h1 at the 2nd edge (MODE 0).
//  2) Incrementing stream, data_in = 1,2,3,... each clock, MODE 0:
//     - data_out tracks data_in[71:0] delayed 2 cycles while channel values stay in 0..127.
//     - At data_in=144'h80 -> data_out=72'h0 (max(-128,0)=0).
//  3) Signed edge, A ch3 = 0x80, B ch3 = 0x7F, all other channels 0:
//     - MODE0 -> ch3 = 0x7F.
//     - MODE1 -> ch3 = 0x00.
//     - MODE2 -> ch3 = 0xFF.
//  4) Saturation, MODE 2:
//     - ch0 0x70+0x70 -> 0x7F.
//     - ch1 0x90+0x90 -> 0x80.
//     - ch2 0x01+0xFF -> 0x00.
//     - All other channels unaffected (0).
//  5) Rounding, MODE 1:
//     - A=5, B=0 -> 0x03.
//     - A=0xFD (-3), B=0 -> 0xFF (-1).
//     - A=0x7F, B=0x7F -> 0x7F.
//  6) Mid-stream reset:
//     - rstn=0 for one edge during the counter stream -> data_out=0 at that edge and the next.
//     - Counter output then resumes with 2-cycle latency.

Source files
------------

// File: rtl/pw_conv_pre_process.sv
// Two-stage pre-processing pipe ahead of the 1x1 conv array: merges two
// adjacent 9-channel INT8 pixels channel-wise into one (max / rounded avg / saturating sum).
module pw_conv_pre_process #(
  parameter int unsigned MODE = 0,
  parameter int unsigned CH   = 9,
  parameter int unsigned DW   = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [2*CH*DW-1:0]     data_in,
  output logic [CH*DW-1:0]       data_out
);

  localparam int unsigned PW = CH * DW;

  logic [2*PW-1:0] s1_q;
  logic [PW-1:0]   data_q;
  logic [PW-1:0]   data_d;

  // Per-channel combine; MODE values outside 0..2 fall back to signed max.
  function automatic logic [DW-1:0] combine(input logic signed [DW-1:0] a,
                                            input logic signed [DW-1:0] b);
    logic signed [DW:0] s;
    logic [DW-1:0]      r;
    s = {a[DW-1], a} + {b[DW-1], b};
    case (MODE)
      1: r = DW'($signed(s + (DW+1)'(1)) >>> 1);
      2: begin
        if (!s[DW] && s[DW-1])      r = {1'b0, {(DW-1){1'b1}}};
        else if (s[DW] && !s[DW-1]) r = {1'b1, {(DW-1){1'b0}}};
        else                        r = s[DW-1:0];
      end
      default: r = (a > b) ? a : b;
    endcase
    return r;
  endfunction

  always_comb begin
    data_d = '0;
    for (int c = 0; c < int'(CH); c++) begin
      data_d[c*DW +: DW] = combine(s1_q[c*DW +: DW], s1_q[PW + c*DW +: DW]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q   <= '0;
      data_q <= '0;
    end else begin
      s1_q   <= data_in;
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_pw_conv_pre_process.sv
// Directed bench for pw_conv_pre_process: one instance per combine mode
// (plus an out-of-range mode) driven from a shared stimulus stream.
module tb_pw_conv_pre_process;

  logic         clk;
  logic         rstn;
  logic [143:0] data_in;
  logic [71:0]  out0, out1, out2, out3;

  int n_checks = 0;
  int n_errors = 0;

  pw_conv_pre_process #(.MODE(0)) dut0 (.clk(clk), .rstn(rstn), .data_in(data_in), .data_out(out0));
  pw_conv_pre_process #(.MODE(1)) dut1 (.clk(clk), .rstn(rstn), .data_in(data_in), .data_out(out1));
  pw_conv_pre_process #(.MODE(2)) dut2 (.clk(clk), .rstn(rstn), .data_in(data_in), .data_out(out2));
  pw_conv_pre_process #(.MODE(3)) dut3 (.clk(clk), .rstn(rstn), .data_in(data_in), .data_out(out3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold a vector long enough for it to reach data_out, then compare all modes.
  task automatic apply_vec(input string tag, input logic [143:0] v,
                           input logic [71:0] e0, input logic [71:0] e1, input logic [71:0] e2);
    data_in = v;
    tick();
    tick();
    check({tag, "_m0"}, out0, e0);
    check({tag, "_m1"}, out1, e1);
    check({tag, "_m2"}, out2, e2);
    check({tag, "_m3"}, out3, e0);
  endtask

  initial begin
    logic [143:0] v;
    logic [71:0]  exp;

    rstn    = 1'b0;
    data_in = 144'h1;

    // Reset held: everything reads zero
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_m0", out0, 72'h0);
      check("rst_m2", out2, 72'h0);
    end

    rstn = 1'b1;
    tick();
    check("rel_edge1", out0, 72'h0);
    tick();
    check("rel_edge2_m0", out0, 72'h1);
    check("rel_edge2_m1", out1, 72'h1);
    check("rel_edge2_m2", out2, 72'h1);

    // Counter stream, MODE 0 output lags input by two edges
    for (int i = 1; i <= 'h82; i++) begin
      data_in = 144'(i);
      tick();
      if (i >= 2) begin
        exp = ((i - 1) < 'h80) ? 72'(i - 1) : 72'h0;
        check("stream_m0", out0, exp);
        check("stream_m3", out3, exp);
      end
    end

    // Signed edge on channel 3
    v = '0;
    v[31:24]  = 8'h80;
    v[103:96] = 8'h7F;
    apply_vec("signed_ch3", v, 72'h7F00_0000, 72'h0, 72'hFF00_0000);

    // Saturation on channels 0..2
    v = '0;
    v[7:0]   = 8'h70; v[79:72] = 8'h70;
    v[15:8]  = 8'h90; v[87:80] = 8'h90;
    v[23:16] = 8'h01; v[95:88] = 8'hFF;
    apply_vec("sat", v, 72'h01_9070, 72'h00_9070, 72'h00_807F);

    // Rounding, negative pairs and the channel-8 extreme
    v = '0;
    v[7:0]   = 8'h05;
    v[15:8]  = 8'hFD;
    v[23:16] = 8'h7F; v[95:88]   = 8'h7F;
    v[31:24] = 8'hFB; v[103:96]  = 8'hFD;
    v[71:64] = 8'h80; v[143:136] = 8'h80;
    apply_vec("round", v,
              72'h80_0000_0000_FD7F_0005,
              72'h80_0000_0000_FC7F_FF03,
              72'h80_0000_0000_F87F_FD05);

    // Single-edge reset in the middle of a counter stream
    for (int j = 1; j <= 12; j++) begin
      data_in = 144'(j);
      rstn    = (j == 6) ? 1'b0 : 1'b1;
      tick();
      if (j >= 2) begin
        exp = (j == 6 || j == 7) ? 72'h0 : 72'(j - 1);
        check("midrst_m0", out0, exp);
      end
    end
    rstn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
